// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - rate-coded spike counter over power-of-two windows plus inter-spike interval tracker
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [2:0]       win_sel,
  input  logic             clear,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic             rate_sat,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  typedef enum logic {IDLE, COUNT} state_t;

  localparam logic [CNT_W-1:0] SPK_MAX = '1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  state_t           state, state_nxt;
  logic             spike_prev;
  logic             evt;
  logic [7:0]       win_cnt;
  logic [7:0]       win_load;
  logic [CNT_W-1:0] spk_cnt, spk_nxt;
  logic             sat, sat_nxt;
  logic             load, win_end, count_en;
  logic [ISI_W-1:0] isi_cnt, isi_step;
  logic             isi_armed;

  assign evt      = spike_in & ~spike_prev;
  assign win_load = 8'((9'd2 << win_sel) - 9'd1);
  assign isi_step = (isi_cnt == ISI_MAX) ? isi_cnt : isi_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    win_end   = 1'b0;
    count_en  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else if (ena) begin
      case (state)
        IDLE: begin
          state_nxt = COUNT;
          load      = 1'b1;
        end
        COUNT: begin
          count_en = 1'b1;
          if (win_cnt == 8'd0) begin
            win_end = 1'b1;
            load    = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counter value including the current cycle's event, used both for counting and for reporting.
  always_comb begin
    spk_nxt = spk_cnt;
    sat_nxt = sat;
    if (evt) begin
      if (spk_cnt == SPK_MAX) sat_nxt = 1'b1;
      else                    spk_nxt = spk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      spike_prev <= 1'b0;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      sat        <= 1'b0;
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      spike_prev <= spike_in;
      rate_valid <= win_end;
      if (win_end) begin
        rate_out <= spk_nxt;
        rate_sat <= sat_nxt;
      end
      if (load) begin
        win_cnt <= win_load;
        spk_cnt <= '0;
        sat     <= 1'b0;
      end else if (count_en) begin
        win_cnt <= win_cnt - 8'd1;
        spk_cnt <= spk_nxt;
        sat     <= sat_nxt;
      end
    end
  end

  // Interval tracking ignores window boundaries and FSM state; only ena and clear gate it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (clear) begin
        isi_cnt   <= '0;
        isi_armed <= 1'b0;
      end else if (ena) begin
        if (evt) begin
          if (isi_armed) begin
            isi_out   <= isi_step;
            isi_valid <= 1'b1;
          end
          isi_armed <= 1'b1;
          isi_cnt   <= '0;
        end else if (isi_armed) begin
          isi_cnt <= isi_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - scoreboard bench for spike_rate_decoder (8-bit and 4-bit instances)
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n, ena, ena4, spike_in, clear;
  logic [2:0] win_sel;
  logic [7:0] rate_out, isi_out;
  logic       rate_valid, rate_sat, isi_valid;
  logic [3:0] r4, i4;
  logic       rv4, rs4, iv4;

  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned ncyc  = 0;
  logic [63:0] q0[$], q1[$], q2[$], q3[$];

  spike_rate_decoder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in), .win_sel(win_sel), .clear(clear),
    .rate_out(rate_out), .rate_valid(rate_valid), .rate_sat(rate_sat),
    .isi_out(isi_out), .isi_valid(isi_valid)
  );

  spike_rate_decoder #(.CNT_W(4), .ISI_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .spike_in(spike_in), .win_sel(win_sel), .clear(clear),
    .rate_out(r4), .rate_valid(rv4), .rate_sat(rs4),
    .isi_out(i4), .isi_valid(iv4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected word: {pad, edge index that registers the output, value, sat}.
  task automatic expect_out(int id, int val, logic s);
    logic [63:0] w;
    w = {23'd0, 32'(ncyc + 1), 8'(val), s};
    case (id)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic pop_check(int id, string tag, logic [63:0] obs);
    logic [63:0] e;
    e = '1;
    case (id)
      0: if (q0.size() != 0) e = q0.pop_front();
      1: if (q1.size() != 0) e = q1.pop_front();
      2: if (q2.size() != 0) e = q2.pop_front();
      default: if (q3.size() != 0) e = q3.pop_front();
    endcase
    check(tag, obs, e);
  endtask

  always @(negedge clk) begin
    if (rate_valid) pop_check(0, "rate8", {23'd0, 32'(ncyc), rate_out, rate_sat});
    if (isi_valid)  pop_check(1, "isi8",  {23'd0, 32'(ncyc), isi_out, 1'b0});
    if (rv4)        pop_check(2, "rate4", {23'd0, 32'(ncyc), 4'd0, r4, rs4});
    if (iv4)        pop_check(3, "isi4",  {23'd0, 32'(ncyc), 4'd0, i4, 1'b0});
  end

  task automatic step(logic e, logic s);
    ena      = e;
    spike_in = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; ena4 = 1'b0; spike_in = 1'b0; win_sel = 3'd0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_main", 64'({rate_out, rate_sat, isi_out, rate_valid, isi_valid}), 64'd0);
    check("reset_dut4", 64'({r4, rs4, i4, rv4, iv4}), 64'd0);
    rst_n = 1'b1;

    // N=8, toggling spikes: rate 4 per window, interval 2
    win_sel = 3'd2;
    step(1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 8; i++) begin
        if ((i % 2 == 0) && (w != 0 || i != 0)) expect_out(1, 2, 1'b0);
        if (i == 7) expect_out(0, 4, 1'b0);
        step(1'b1, (i % 2) == 0);
      end
    end

    // clear, then win_sel 1 -> 3 mid-window; events 5 apart
    clear = 1'b1;
    step(1'b1, 1'b0);
    clear = 1'b0;
    win_sel = 3'd1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) win_sel = 3'd3;
      if (i == 3) expect_out(0, 0, 1'b0);
      step(1'b1, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 8 || i == 13) expect_out(1, 5, 1'b0);
      if (i == 15) expect_out(0, 3, 1'b0);
      step(1'b1, i == 3 || i == 8 || i == 13);
    end

    // ena low for 3 cycles mid-window with pulses that must be ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 5; i < 16; i++) begin
      if (i == 7) expect_out(1, 10, 1'b0);
      if (i == 15) expect_out(0, 1, 1'b0);
      step(1'b1, i == 7);
    end

    // clear after 3 events, next full window counts only its own
    for (int i = 0; i < 6; i++) begin
      if (i == 0) expect_out(1, 9, 1'b0);
      if (i == 2 || i == 4) expect_out(1, 2, 1'b0);
      step(1'b1, i == 0 || i == 2 || i == 4);
    end
    clear = 1'b1;
    step(1'b1, 1'b0);
    clear = 1'b0;
    win_sel = 3'd2;
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) expect_out(1, 4, 1'b0);
      if (i == 7) expect_out(0, 2, 1'b0);
      step(1'b1, i == 1 || i == 5);
    end

    // async reset after 3 events of a window
    for (int i = 0; i < 6; i++) begin
      if (i == 0) expect_out(1, 3, 1'b0);
      if (i == 2 || i == 4) expect_out(1, 2, 1'b0);
      step(1'b1, i == 0 || i == 2 || i == 4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", 64'({rate_out, rate_sat, isi_out, rate_valid, isi_valid}), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    win_sel = 3'd1;
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) expect_out(0, 1, 1'b0);
      step(1'b1, i == 1);
    end

    // 4-bit instance: N=256 saturates rate at 15, long gap saturates interval at 15
    ena4 = 1'b1;
    win_sel = 3'd7;
    step(1'b0, 1'b0);
    for (int i = 0; i < 256; i++) begin
      if ((i % 2 == 0) && i != 0) expect_out(3, 2, 1'b0);
      if (i == 255) expect_out(2, 15, 1'b1);
      step(1'b0, (i % 2) == 0);
    end
    for (int i = 0; i <= 20; i++) begin
      if (i == 20) expect_out(3, 15, 1'b0);
      step(1'b0, i == 20);
    end
    ena4 = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    check("pending_rate8", 64'(q0.size()), 64'd0);
    check("pending_isi8",  64'(q1.size()), 64'd0);
    check("pending_rate4", 64'(q2.size()), 64'd0);
    check("pending_isi4",  64'(q3.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of rate_out; legal range 4..8.
REQ-002 SHALL have parameter ISI_W, default 8: width of isi_out; legal range 4..8.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  block enable; low freezes counting.
REQ-006 SHALL have port spike_in  input  1  spike train from a LIF neuron, same clock domain.
REQ-007 SHALL have port win_sel  input  3  window length select; N = 2^(win_sel+1) cycles (2..256).
REQ-008 SHALL have port clear  input  1  synchronous abort/restart of current window.
REQ-009 SHALL have port rate_out  output  CNT_W  spike count of last completed window.
REQ-010 SHALL have port rate_valid  output  1  one-cycle pulse when rate_out updates.
REQ-011 SHALL have port rate_sat  output  1  rate_out of last window saturated.
REQ-012 SHALL have port isi_out  output  ISI_W  cycles between the last two spike events.
REQ-013 SHALL have port isi_valid  output  1  one-cycle pulse when isi_out updates.

Function
REQ-014 SHALL define a spike event as a cycle where spike_in=1 and its registered previous sample=0 (rising edge); the previous-sample register updates every cycle regardless of ena.
REQ-015 SHALL implement FSM states IDLE and COUNT; reset enters IDLE.
REQ-016 IDLE: when ena=1, SHALL latch win_sel, load window counter with N-1, clear spike counter, go to COUNT next cycle; no event in the IDLE cycle is counted.
REQ-017 COUNT: each cycle with ena=1, SHALL add 1 to spike counter on an event and decrement window counter.
REQ-018 Spike counter SHALL saturate at 2^CNT_W-1; further events in that window set an internal sat bit.
REQ-019 At the cycle where window counter=0 (window's last cycle) with ena=1, SHALL register rate_out = counter including that cycle's event, rate_sat = sat bit, and assert rate_valid for exactly the next cycle.
REQ-020 On that same edge SHALL re-latch win_sel, reload window counter with new N-1, and reset spike counter and sat bit to 0; windows are back-to-back with no gap cycle.
REQ-021 win_sel changes mid-window SHALL take effect only at the next window boundary.
REQ-022 ena=0 in COUNT SHALL hold window counter, spike counter, and all outputs; events seen while ena=0 SHALL be discarded; rate_valid and isi_valid SHALL be 0.
REQ-023 clear=1 (ena ignored) SHALL discard current window, force rate_valid=0 and isi_valid=0 next cycle, reset ISI tracking, and return FSM to IDLE; rate_out, rate_sat, isi_out hold.
REQ-024 ISI counter SHALL increment every ena=1 cycle after the first event, saturating at 2^ISI_W-1.
REQ-025 On each event after the first, SHALL register isi_out = cycles since previous event (ISI counter+1, saturating), pulse isi_valid next cycle, and restart ISI counter at 0.
REQ-026 First event after reset or clear SHALL start ISI tracking without asserting isi_valid.
REQ-027 ISI tracking SHALL run in both FSM states and is independent of window boundaries.

Reset
REQ-028 rst_n=0 SHALL immediately force: FSM=IDLE, rate_out=0, rate_valid=0, rate_sat=0, isi_out=0, isi_valid=0, all counters 0, previous-sample register 0, ISI tracking unarmed.
REQ-029 Reset asserted mid-window SHALL discard partial count; no rate_valid until a full window completes after release.

Verification
REQ-030 win_sel=2 (N=8), ena=1, spike_in toggling every cycle from window start -> rate_out=4, rate_valid single pulse every 8 cycles, rate_sat=0.
REQ-031 CNT_W=4, win_sel=7 (N=256), spike_in toggling every cycle -> rate_out=15, rate_sat=1.
REQ-032 Events 5 cycles apart, ena=1 -> first event no isi_valid; each later event gives isi_out=5 with one-cycle isi_valid.
REQ-033 win_sel changed 1->3 mid-window -> current window still 4 cycles, next window 16 cycles.
REQ-034 ena dropped 3 cycles mid-window with spike_in pulses during that time -> window extends 3 cycles, those pulses not counted, no valid pulses while low.
REQ-035 clear or rst_n asserted mid-window after 3 events -> no rate_valid for partial window; next full window reports only its own events.
